// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields, ALU flags, memory handshake in;
// datapath enables/selects, state and instruction counters out.
interface multicycle_controller_if #(
  parameter int CNT_W = 16
);
  // datapath -> controller
  logic [5:0]       op;
  logic [5:0]       fun;
  logic             zero;
  logic             overflow;
  logic             mem_ready;
  // controller -> datapath
  logic             PCWr;
  logic             IRWr;
  logic             RegWr;
  logic             MemWr;
  logic             MemRd;
  logic             ALUSrc;
  logic [1:0]       RegDst;
  logic [1:0]       MemToReg;
  logic [1:0]       nPC_sel;
  logic [1:0]       ExtOp;
  logic [2:0]       ALUCtr;
  logic [2:0]       state;
  logic             retire;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] ill_cnt;

  // datapath side
  modport master (
    output op, fun, zero, overflow, mem_ready,
    input  PCWr, IRWr, RegWr, MemWr, MemRd, ALUSrc, RegDst, MemToReg,
           nPC_sel, ExtOp, ALUCtr, state, retire, illegal, instr_cnt, ill_cnt
  );

  // controller side
  modport slave (
    input  op, fun, zero, overflow, mem_ready,
    output PCWr, IRWr, RegWr, MemWr, MemRd, ALUSrc, RegDst, MemToReg,
           nPC_sel, ExtOp, ALUCtr, state, retire, illegal, instr_cnt, ill_cnt
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: IF/ID/EXE/MEM/WB sequencing for
// addu subu slt jr addi addiu ori lui lw sw beq j jal, with memory
// ready stalls, selectable addi overflow policy and retire/illegal counters.
module multicycle_controller #(
  parameter bit USE_READY = 1'b1,
  parameter bit OVF_MODE  = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic                    clk,
  input logic                    rst,   // async, active-low
  multicycle_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  // one-hot-ish instruction classes decoded from op/fun
  typedef struct packed {
    logic rtype;   // op == 0 (selects rd as destination)
    logic r_alu;   // addu/subu/slt
    logic jr;
    logic addi;
    logic addiu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic ill;
  } dec_t;

  state_e           state_q, state_d;
  logic             ovf_q;
  logic [CNT_W-1:0] instr_cnt_q, ill_cnt_q;
  dec_t             dec;
  logic             rdy;

  // raw (pre-reset-gating) controls
  logic       pcwr, irwr, regwr, memwr, memrd, ret, ill;
  logic [1:0] regdst, m2r, npc;
  logic [2:0] alu_ctr;
  logic [1:0] ext_op;
  logic       alu_src;

  assign rdy = USE_READY ? bus.mem_ready : 1'b1;

  // instruction decode from IR fields
  always_comb begin
    dec       = '0;
    dec.rtype = (bus.op == 6'h00);
    case (bus.op)
      6'h00: begin
        case (bus.fun)
          6'h21, 6'h23, 6'h2A: dec.r_alu = 1'b1;
          6'h08:               dec.jr    = 1'b1;
          default:             dec.ill   = 1'b1;
        endcase
      end
      6'h08:   dec.addi  = 1'b1;
      6'h09:   dec.addiu = 1'b1;
      6'h0D:   dec.ori   = 1'b1;
      6'h0F:   dec.lui   = 1'b1;
      6'h23:   dec.lw    = 1'b1;
      6'h2B:   dec.sw    = 1'b1;
      6'h04:   dec.beq   = 1'b1;
      6'h02:   dec.j     = 1'b1;
      6'h03:   dec.jal   = 1'b1;
      default: dec.ill   = 1'b1;
    endcase
  end

  // ALU/extender selects; stable for the whole instruction since IR is held
  always_comb begin
    alu_ctr = 3'b000;
    ext_op  = 2'b00;
    alu_src = 1'b0;
    if (dec.r_alu) begin
      case (bus.fun)
        6'h23:   alu_ctr = 3'b001;
        6'h2A:   alu_ctr = 3'b100;
        default: alu_ctr = 3'b000;
      endcase
    end
    if (dec.addi)  begin alu_ctr = 3'b011; ext_op = 2'b01; alu_src = 1'b1; end
    if (dec.addiu) begin alu_ctr = 3'b000; ext_op = 2'b01; alu_src = 1'b1; end
    if (dec.ori)   begin alu_ctr = 3'b010; ext_op = 2'b00; alu_src = 1'b1; end
    if (dec.lui)   begin alu_ctr = 3'b101; ext_op = 2'b10; alu_src = 1'b1; end
    if (dec.lw || dec.sw) begin
      alu_ctr = 3'b000; ext_op = 2'b01; alu_src = 1'b1;
    end
    if (dec.beq)   begin alu_ctr = 3'b001; ext_op = 2'b01; alu_src = 1'b0; end
  end

  // next-state and per-state enables
  always_comb begin
    state_d = state_q;
    pcwr    = 1'b0;
    irwr    = 1'b0;
    regwr   = 1'b0;
    memwr   = 1'b0;
    memrd   = 1'b0;
    ret     = 1'b0;
    ill     = 1'b0;
    regdst  = 2'b00;
    m2r     = 2'b00;
    npc     = 2'b00;
    case (state_q)
      S_IF: begin
        memrd = 1'b1;
        if (rdy) begin
          irwr    = 1'b1;
          pcwr    = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        state_d = S_EXE;
        if (dec.ill) begin
          ill     = 1'b1;
          state_d = S_IF;
        end else if (dec.j || dec.jal) begin
          pcwr    = 1'b1;
          npc     = 2'b01;
          ret     = 1'b1;
          state_d = S_IF;
          if (dec.jal) begin
            regwr  = 1'b1;
            regdst = 2'b10;
            m2r    = 2'b10;
          end
        end else if (dec.jr) begin
          pcwr    = 1'b1;
          npc     = 2'b10;
          ret     = 1'b1;
          state_d = S_IF;
        end
      end
      S_EXE: begin
        if (dec.beq) begin
          pcwr    = bus.zero;
          npc     = 2'b11;
          ret     = 1'b1;
          state_d = S_IF;
        end else if (dec.lw || dec.sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // strobe stays up until the ready cycle, which is the access itself
        if (dec.lw) begin
          memrd = 1'b1;
          if (rdy) state_d = S_WB;
        end else begin
          memwr = 1'b1;
          if (rdy) begin
            ret     = 1'b1;
            state_d = S_IF;
          end
        end
      end
      S_WB: begin
        regwr   = 1'b1;
        ret     = 1'b1;
        state_d = S_IF;
        regdst  = dec.rtype ? 2'b01 : 2'b00;
        m2r     = dec.lw ? 2'b01 : 2'b00;
        if (dec.addi && ovf_q) begin
          if (OVF_MODE) regdst = 2'b11;
          else          regwr  = 1'b0;
        end
      end
      default: state_d = S_IF;
    endcase
  end

  // state and captured addi overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXE) ovf_q <= bus.overflow & dec.addi;
    end
  end

  // retired / illegal counters, wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_cnt_q <= '0;
      ill_cnt_q   <= '0;
    end else begin
      if (ret) instr_cnt_q <= instr_cnt_q + 1'b1;
      if (ill) ill_cnt_q   <= ill_cnt_q + 1'b1;
    end
  end

  // write-type strobes are held off for the whole reset window
  assign bus.PCWr      = rst & pcwr;
  assign bus.IRWr      = rst & irwr;
  assign bus.RegWr     = rst & regwr;
  assign bus.MemWr     = rst & memwr;
  assign bus.MemRd     = rst & memrd;
  assign bus.retire    = rst & ret;
  assign bus.illegal   = rst & ill;
  assign bus.RegDst    = regdst;
  assign bus.MemToReg  = m2r;
  assign bus.nPC_sel   = npc;
  assign bus.ALUCtr    = alu_ctr;
  assign bus.ExtOp     = ext_op;
  assign bus.ALUSrc    = alu_src;
  assign bus.state     = state_q;
  assign bus.instr_cnt = instr_cnt_q;
  assign bus.ill_cnt   = ill_cnt_q;

endmodule
